// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes I/S/B/U/J immediates in stage 0 and carries them through
// a valid/ready pipeline of PIPE_DEPTH stages. Optional IMM_GEN_STATS_EN adds the imm_count output.
module imm_gen_pipe #(
    parameter int XLEN       = 64,
    parameter int PIPE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            no_imm
`ifdef IMM_GEN_STATS_EN
    ,
    output logic [15:0]     imm_count
`endif
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            no_imm;
    } payload_t;

    fmt_e        dec_fmt;
    logic [31:0] dec_raw;
    payload_t    dec;

    // Every immediate is first built as a 32-bit sign-extended value, then widened to XLEN.
    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        dec_fmt = FMT_NONE;
        dec_raw = 32'd0;
        unique case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_raw = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_raw = {instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
        dec.imm    = XLEN'(signed'(dec_raw));
        dec.fmt    = dec_fmt;
        dec.no_imm = (dec_fmt == FMT_NONE);
    end

    logic     vld [PIPE_DEPTH];
    payload_t pay [PIPE_DEPTH];
    logic     rdy [PIPE_DEPTH+1];

    assign rdy[PIPE_DEPTH] = out_ready;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        payload_t src_pay;
        logic     src_vld;

        if (k == 0) begin : g_head
            assign src_pay = dec;
            assign src_vld = in_valid;
        end else begin : g_body
            assign src_pay = pay[k-1];
            assign src_vld = vld[k-1];
        end

        // A stage can take new data when it is empty or its occupant moves on this cycle.
        assign rdy[k] = !vld[k] || rdy[k+1];

        // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
        always_ff @(posedge clk) begin
            if (!rst_n) vld[k] <= 1'b0;
            else if (rdy[k]) vld[k] <= src_vld;
        end

        if (k == PIPE_DEPTH - 1) begin : g_out
            // The output payload is forced to zero whenever no valid entry sits in it.
            always_ff @(posedge clk) begin
                if (!rst_n) pay[k] <= '0;
                else if (rdy[k]) pay[k] <= src_vld ? src_pay : '0;
            end
        end else begin : g_mid
            // NOTE: inner payload registers are not reset; their contents only matter when vld is set.
            always_ff @(posedge clk) begin
                if (rdy[k]) pay[k] <= src_pay;
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[PIPE_DEPTH-1];
    assign imm       = pay[PIPE_DEPTH-1].imm;
    assign fmt       = pay[PIPE_DEPTH-1].fmt;
    assign no_imm    = pay[PIPE_DEPTH-1].no_imm;

`ifdef IMM_GEN_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) imm_count <= 16'd0;
        else if (out_valid && out_ready && !no_imm && imm_count != 16'hFFFF)
            imm_count <= imm_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised + directed bench for imm_gen_pipe: a queue-based reference model is compared every cycle,
// plus literal expectations for the documented instruction examples and a 32-bit instance.
module tb_imm_gen_pipe;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, no_imm;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;

    logic        in32_valid, in32_ready, out32_valid, no_imm32;
    logic [31:0] instr32, imm32;
    logic [2:0]  fmt32;

`ifdef IMM_GEN_STATS_EN
    logic [15:0] imm_count, imm_count32;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .fmt(fmt), .no_imm(no_imm)
`ifdef IMM_GEN_STATS_EN
        , .imm_count(imm_count)
`endif
    );

    imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in32_valid), .in_ready(in32_ready), .instr(instr32),
        .out_valid(out32_valid), .out_ready(1'b1), .imm(imm32), .fmt(fmt32), .no_imm(no_imm32)
`ifdef IMM_GEN_STATS_EN
        , .imm_count(imm_count32)
`endif
    );

    typedef struct {
        longint imm;
        int     fmt;
        bit     no_imm;
        longint stamp;
    } exp_t;

    exp_t   q[$];
    int     compared   = 0;
    int     mismatched = 0;
    longint cyc        = 0;
    bit     started    = 1'b0;
    int unsigned cnt_model = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode using signed arithmetic on the instruction word.
    function automatic exp_t model(input logic [31:0] w);
        exp_t   e;
        longint s   = longint'(signed'(w));
        longint sgn = s >>> 31;
        e.imm = 0; e.fmt = 0; e.no_imm = 1'b1; e.stamp = 0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                e.fmt = 1; e.imm = s >>> 20;
            end
            7'b0100011: begin
                e.fmt = 2; e.imm = (s >>> 25) * 32 + longint'(w[11:7]);
            end
            7'b1100011: begin
                e.fmt = 3;
                e.imm = sgn * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = 4; e.imm = longint'(signed'(w & 32'hFFFFF000));
            end
            7'b1101111: begin
                e.fmt = 5;
                e.imm = sgn * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                      + longint'(w[30:21]) * 2;
            end
            default: ;
        endcase
        e.no_imm = (e.fmt == 0);
        return e;
    endfunction

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit   exp_ov, exp_ir;
        exp_t e;
        exp_ov = (q.size() > 0) && ((cyc - q[0].stamp) >= D - 1);
        exp_ir = (q.size() < D) || out_ready;
        if (started) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
            check("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
            check("imm", imm, exp_ov ? q[0].imm : 64'd0);
            check("fmt", {61'd0, fmt}, exp_ov ? 64'(q[0].fmt) : 64'd0);
            check("no_imm", {63'd0, no_imm}, exp_ov ? {63'd0, q[0].no_imm} : 64'd0);
`ifdef IMM_GEN_STATS_EN
            check("imm_count", {48'd0, imm_count}, 64'(cnt_model));
`endif
        end
        if (!rst_n) begin
            q.delete();
            cnt_model = 0;
            started   = 1'b1;
        end else if (started) begin
            if (exp_ov && out_ready) begin
                if (!q[0].no_imm && cnt_model != 32'hFFFF) cnt_model++;
                void'(q.pop_front());
            end
            if (in_valid && exp_ir) begin
                e = model(instr);
                e.stamp = cyc + 1;
                q.push_back(e);
            end
        end
        cyc++;
    end

    // Present one instruction and hold it until accepted; returns #1 after the accept edge.
    task automatic send(input logic [31:0] w);
        bit acc;
        in_valid = 1'b1;
        instr    = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] w, input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
        in32_valid = 1'b1;
        instr32    = w;
        @(posedge clk);
        #1;
        in32_valid = 1'b0;
        check("x32_valid", {63'd0, out32_valid}, 64'd1);
        check("x32_imm", {32'd0, imm32}, {32'd0, exp_imm});
        check("x32_fmt", {61'd0, fmt32}, {61'd0, exp_fmt});
        check("x32_no_imm", {63'd0, no_imm32}, {63'd0, exp_fmt == 3'd0});
    endtask

    logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};

    initial begin
        exp_t        p;
        bit          acc;
        logic [31:0] r;
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b1;
        in32_valid = 1'b0; instr32 = 32'd0;
        idle(2);
        rst_n = 1'b1;

        p = model(32'hFFD00093); check("pin_addi", p.imm, 64'hFFFFFFFFFFFFFFFD);
        p = model(32'hFE512E23); check("pin_sw", p.imm, 64'hFFFFFFFFFFFFFFFC);
        p = model(32'h00000863); check("pin_beq", p.imm, 64'h10);
        p = model(32'h800000B7); check("pin_lui", p.imm, 64'hFFFFFFFF80000000);
        p = model(32'h0000006F | 32'h80000000); check("pin_jal", p.imm, 64'hFFFFFFFFFFF00000);

        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);

        send(32'hFFD00093);
        idle(1);
        check("addi_valid", {63'd0, out_valid}, 64'd1);
        check("addi_imm", imm, 64'hFFFFFFFFFFFFFFFD);
        check("addi_fmt", {61'd0, fmt}, 64'd1);
        idle(2);

        send(32'hFE512E23);
        send(32'h00000863);
        check("sw_imm", imm, 64'hFFFFFFFFFFFFFFFC);
        check("sw_fmt", {61'd0, fmt}, 64'd2);
        idle(1);
        check("beq_imm", imm, 64'h10);
        check("beq_fmt", {61'd0, fmt}, 64'd3);
        idle(2);

        send(32'h800000B7);
        send(32'h00000033);
        idle(3);

        send32(32'h800000B7, 32'h80000000, 3'd4);
        send32(32'hFFD00093, 32'hFFFFFFFD, 3'd1);
        send32(32'h00000033, 32'h00000000, 3'd0);

        // Backpressure: two entries fill the pipe, the third waits.
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        in_valid = 1'b1; instr = 32'h00300193;
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        idle(3);
        check("bp_hold_imm", imm, 64'd1);
        check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        send(32'h00300193);
        idle(4);

        // Reset with two entries in flight.
        out_ready = 1'b0;
        send(32'h00500293);
        send(32'h00600313);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        idle(4);

        // Randomised traffic with random stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            rst_n     = ($urandom_range(0, 299) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc || !rst_n) begin
                r        = $urandom();
                in_valid = ($urandom_range(0, 3) != 0);
                instr    = {r[31:7], ops[$urandom_range(0, 11)]};
            end
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        idle(4);

`ifdef IMM_GEN_STATS_EN
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send(32'hFFD00093);
        send(32'h00000033);
        idle(4);
        check("stats_five", {48'd0, imm_count}, 64'd5);
        in_valid = 1'b1; instr = 32'h00100093;
        repeat (65540) @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(4);
        check("stats_sat", {48'd0, imm_count}, 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3_000_000;
        mismatched++;
        $display("FAIL global_timeout: got no finish, expected finish before t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

endmodule
